// File: rtl/main_bist.sv
// main_bist: USB SYNC-pattern detector with LFSR/MISR built-in self-test
module main_bist #(
    parameter int          BIST_CYCLES = 255,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic CLK,
    input  logic RST,
    input  logic bist_start,
    input  logic in_k,
    input  logic in_j,
    input  logic in_en,
    output logic out_synced_d,
    output logic out_sync_err_d,
    output logic pass_fail,
    output logic bist_end
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam logic [7:0] LAST = 8'(BIST_CYCLES - 1);
    state_t      r_state;
    logic        r_start_q;
    logic [15:0] r_lfsr;
    logic [15:0] r_misr;
    logic [7:0]  r_cnt;
    logic [2:0]  r_det;
    logic        w_start;
    logic        w_entry;
    logic        w_run;
    logic        w_k;
    logic        w_j;
    logic        w_en;
    logic        w_exp_k;
    logic        w_match;
    logic        w_lfsr_fb;
    logic [15:0] w_misr_next;
    assign w_start     = bist_start & ~r_start_q;
    assign w_entry     = w_start & (r_state != S_RUN);
    assign w_run       = (r_state == S_RUN);
    assign w_k         = w_run ? r_lfsr[0] : in_k;
    assign w_j         = w_run ? r_lfsr[1] : in_j;
    assign w_en        = w_run ? r_lfsr[2] : in_en;
    assign w_exp_k     = (r_det == 3'd7) | ~r_det[0];
    assign w_match     = w_exp_k ? (w_k & ~w_j) : (~w_k & w_j);
    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_misr_next = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10]}
                       ^ {14'b0, out_sync_err_d, out_synced_d};
    // SYNC detector: tracks matched symbols, restarts cleanly when a self-test begins
    always_ff @(posedge CLK) begin
        if (!RST || w_entry) begin
            r_det          <= 3'd0;
            out_synced_d   <= 1'b0;
            out_sync_err_d <= 1'b0;
        end else begin
            out_synced_d   <= w_en & w_match & (r_det == 3'd7);
            out_sync_err_d <= w_en & ~w_match & (r_det != 3'd0);
            if (w_en)
                r_det <= (w_match && r_det != 3'd7) ? r_det + 3'd1 : 3'd0;
        end
    end
    // BIST controller: start-edge detect, pattern generation, signature compaction and verdict
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_lfsr    <= 16'h0;
            r_misr    <= 16'h0;
            r_cnt     <= 8'h0;
            bist_end  <= 1'b0;
            pass_fail <= 1'b0;
        end else begin
            r_start_q <= bist_start;
            if (w_entry) begin
                r_state   <= S_RUN;
                r_lfsr    <= 16'hACE1;
                r_misr    <= 16'h0;
                r_cnt     <= 8'h0;
                bist_end  <= 1'b0;
                pass_fail <= 1'b0;
            end else if (w_run) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
                r_misr <= w_misr_next;
                r_cnt  <= r_cnt + 8'd1;
                if (r_cnt == LAST) begin
                    r_state   <= S_DONE;
                    bist_end  <= 1'b1;
                    pass_fail <= (w_misr_next == GOLDEN_SIG);
                end
            end
        end
    end
endmodule

// File: tb/tb_main_bist.sv
// tb_main_bist: directed scoreboard bench for main_bist (detector and self-test)
module tb_main_bist;
    localparam int CYC = 255;

    // reference detector step: returns {next_pos, synced, err}
    function automatic logic [4:0] det_next(input logic [2:0] p, input logic k, input logic j, input logic en);
        logic [7:0] pat;
        logic       want_k;
        logic       ok;
        pat = 8'hD5;
        if (!en) return {p, 2'b00};
        want_k = pat[p];
        ok = want_k ? (k && !j) : (!k && j);
        if (ok) return (p == 3'd7) ? 5'b000_10 : {p + 3'd1, 2'b00};
        return (p == 3'd0) ? 5'b000_00 : 5'b000_01;
    endfunction

    // reference signature of a fault-free run of n pattern cycles
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] l;
        logic [15:0] m;
        logic [4:0]  d;
        logic [2:0]  p;
        logic        s;
        logic        e;
        l = 16'hACE1; m = 16'h0; p = 3'd0; s = 1'b0; e = 1'b0;
        for (int c = 0; c < n; c++) begin
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {14'b0, e, s};
            d = det_next(p, l[0], l[1], l[2]);
            p = d[4:2]; s = d[1]; e = d[0];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = model_sig(CYC);

    logic clk = 1'b0;
    logic rst_n, bist_start, in_k, in_j, in_en;
    logic synced, sync_err, pass_fail, bist_end;
    logic f_synced, f_sync_err, f_pass_fail, f_bist_end;
    int errors = 0;
    int checks = 0;
    logic [2:0] p_m;
    logic [1:0] det_q[$];
    logic [2:0] bist_q[$];

    always #5 clk = ~clk;

    main_bist #(.BIST_CYCLES(CYC), .GOLDEN_SIG(GOLD)) dut (
        .CLK(clk), .RST(rst_n), .bist_start(bist_start),
        .in_k(in_k), .in_j(in_j), .in_en(in_en),
        .out_synced_d(synced), .out_sync_err_d(sync_err),
        .pass_fail(pass_fail), .bist_end(bist_end)
    );

    main_bist #(.BIST_CYCLES(CYC), .GOLDEN_SIG(GOLD ^ 16'h0001)) dut_f (
        .CLK(clk), .RST(rst_n), .bist_start(bist_start),
        .in_k(in_k), .in_j(in_j), .in_en(in_en),
        .out_synced_d(f_synced), .out_sync_err_d(f_sync_err),
        .pass_fail(f_pass_fail), .bist_end(f_bist_end)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic k, input logic j, input logic en);
        logic [4:0] d;
        logic [1:0] x;
        in_k = k; in_j = j; in_en = en;
        d = det_next(p_m, k, j, en);
        p_m = d[4:2];
        det_q.push_back(d[1:0]);
        tick;
        x = det_q.pop_front();
        chk("synced", int'(synced), int'(x[1]));
        chk("sync_err", int'(sync_err), int'(x[0]));
    endtask

    task automatic send_sync;
        for (int i = 0; i < 8; i++)
            if (i % 2 == 0 || i == 7) step(1, 0, 1); else step(0, 1, 1);
    endtask

    task automatic run_bist(input string tag);
        int n;
        bit seen;
        logic [2:0] x;
        bist_q.push_back(3'b110);
        bist_start = 1'b1;
        tick;
        chk({tag, "_end_drop"}, int'(bist_end), 0);
        n = 0;
        seen = 0;
        while (n < CYC + 20 && !seen) begin
            tick;
            n++;
            if (n == 9) bist_start = 1'b0;
            if (bist_end) seen = 1;
        end
        chk({tag, "_latency"}, n, CYC);
        x = bist_q.pop_front();
        chk({tag, "_end"}, int'(bist_end), int'(x[2]));
        chk({tag, "_pass"}, int'(pass_fail), int'(x[1]));
        chk({tag, "_fail_dut_pass"}, int'(f_pass_fail), int'(x[0]));
        chk({tag, "_fail_dut_end"}, int'(f_bist_end), 1);
        for (int i = 0; i < 5; i++) tick;
        chk({tag, "_end_held"}, int'(bist_end), 1);
        chk({tag, "_pass_held"}, int'(pass_fail), 1);
    endtask

    initial begin
        bit any_end;
        rst_n = 1'b0; bist_start = 1'b1; in_k = 1'b0; in_j = 1'b0; in_en = 1'b0;
        p_m = 3'd0;
        tick; tick;
        chk("rst_synced", int'(synced), 0);
        chk("rst_err", int'(sync_err), 0);
        chk("rst_pass", int'(pass_fail), 0);
        chk("rst_end", int'(bist_end), 0);
        chk("rst_f_end", int'(f_bist_end), 0);
        rst_n = 1'b1;
        tick; tick; tick;
        chk("rel_end", int'(bist_end), 0);
        chk("rel_pass", int'(pass_fail), 0);
        rst_n = 1'b0; bist_start = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        p_m = 3'd0;
        step(0, 0, 1);
        send_sync;
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
        step(1, 0, 1); step(0, 1, 1); step(0, 1, 1);
        step(1, 0, 1); step(0, 1, 1);
        step(0, 0, 0); step(1, 1, 0);
        step(1, 0, 1); step(0, 1, 1); step(1, 0, 1); step(0, 1, 1); step(1, 0, 1); step(1, 0, 1);
        step(1, 0, 1); step(0, 1, 1); step(1, 0, 1); step(1, 1, 1);
        send_sync;
        step(1, 0, 1); step(0, 1, 1); step(1, 0, 1); step(0, 1, 1);
        step(1, 0, 1); step(0, 1, 1); step(1, 0, 1); step(0, 1, 1);
        in_en = 1'b0;
        run_bist("pass");
        run_bist("rerun_done");
        bist_start = 1'b1;
        tick;
        for (int i = 1; i <= 100; i++) begin
            tick;
            if (i == 9) bist_start = 1'b0;
        end
        rst_n = 1'b0;
        tick; tick;
        chk("midrst_end", int'(bist_end), 0);
        chk("midrst_pass", int'(pass_fail), 0);
        rst_n = 1'b1;
        any_end = 0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (bist_end) any_end = 1;
        end
        chk("midrst_no_end", int'(any_end), 0);
        run_bist("restart");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
